// File: rtl/tmp2_bcd.sv
// tmp2_bcd: converts a raw ADT7420 temperature word (value/128 degC) into
// sign-magnitude decimal: 3 BCD integer digits and 4 truncated BCD
// fraction digits. The integer part uses a 9-step double dabble and the
// fraction part uses 4 multiply-by-10 steps, so each conversion takes
// 14 cycles from the accepting edge to the valid_o pulse.
module tmp2_bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [15:0] temperature_i,
  input  logic        resolution_i,
  output logic        busy,
  output logic        valid_o,
  output logic        sign_o,
  output logic [11:0] int_bcd_o,
  output logic [15:0] frac_bcd_o,
  output logic        overrun_o
);

  typedef enum logic [1:0] {IDLE, INT, FRAC, DONE} state_t;

  state_t      state;
  logic        sign_reg;
  logic [8:0]  int_src;   // integer magnitude, consumed MSB first
  logic [11:0] int_acc;   // BCD integer accumulator
  logic [6:0]  frac_rem;  // remaining fraction numerator (over 128)
  logic [15:0] frac_acc;  // BCD fraction accumulator
  logic [3:0]  step;

  logic [15:0] word_masked;
  logic [15:0] mag;
  logic [7:0]  int_adj;
  logic [11:0] int_next;
  logic [10:0] frac_prod;
  logic [15:0] frac_next;

  // In 13-bit mode the low three bits are flags, not temperature data.
  // Two's-complement negation of 0x8000 wraps to 0x8000, which is the
  // correct unsigned magnitude.
  always_comb begin
    word_masked = resolution_i ? temperature_i : {temperature_i[15:3], 3'b000};
    mag         = word_masked[15] ? (~word_masked + 16'd1) : word_masked;
  end

  // Add-3 correction for the units and tens digits. The hundreds digit
  // tops out at 2 (largest magnitude is 256) and never needs correcting.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dabble
      assign int_adj[gi*4 +: 4] = (int_acc[gi*4 +: 4] >= 4'd5) ?
                                  int_acc[gi*4 +: 4] + 4'd3 :
                                  int_acc[gi*4 +: 4];
    end
  endgenerate

  // Shift the corrected accumulator left, pulling in the next source bit.
  always_comb begin
    int_next = {int_acc[10:8], int_adj, int_src[8]};
  end

  // One decimal fraction digit per step: the integer part of rem*10/128.
  always_comb begin
    frac_prod = {4'b0000, frac_rem} * 11'd10;
    frac_next = {frac_acc[11:0], frac_prod[10:7]};
  end

  // Conversion FSM with registered result, status and strobe outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sign_reg   <= 1'b0;
      int_src    <= '0;
      int_acc    <= '0;
      frac_rem   <= '0;
      frac_acc   <= '0;
      step       <= '0;
      busy       <= 1'b0;
      valid_o    <= 1'b0;
      sign_o     <= 1'b0;
      int_bcd_o  <= '0;
      frac_bcd_o <= '0;
      overrun_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      // A strobe arriving while a conversion is in flight is dropped.
      if (valid_i && state != IDLE) begin
        overrun_o <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (valid_i) begin
            sign_reg  <= word_masked[15];
            int_src   <= mag[15:7];
            frac_rem  <= mag[6:0];
            int_acc   <= '0;
            frac_acc  <= '0;
            step      <= '0;
            overrun_o <= 1'b0;
            busy      <= 1'b1;
            state     <= INT;
          end
        end
        INT: begin
          int_acc <= int_next;
          int_src <= {int_src[7:0], 1'b0};
          if (step == 4'd8) begin
            step  <= '0;
            state <= FRAC;
          end else begin
            step <= step + 4'd1;
          end
        end
        FRAC: begin
          frac_acc <= frac_next;
          frac_rem <= frac_prod[6:0];
          if (step == 4'd3) begin
            // Publish results so they are visible during the DONE cycle.
            step       <= '0;
            sign_o     <= sign_reg;
            int_bcd_o  <= int_acc;
            frac_bcd_o <= frac_next;
            valid_o    <= 1'b1;
            state      <= DONE;
          end else begin
            step <= step + 4'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmp2_bcd.sv
// Testbench for tmp2_bcd: directed vectors, overrun and reset scenarios,
// and random words compared against an arithmetic reference model.
module tb_tmp2_bcd;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [15:0] temperature_i;
  logic        resolution_i;
  logic        busy;
  logic        valid_o;
  logic        sign_o;
  logic [11:0] int_bcd_o;
  logic [15:0] frac_bcd_o;
  logic        overrun_o;

  int n_checks = 0;
  int n_fail   = 0;

  tmp2_bcd dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .temperature_i (temperature_i),
    .resolution_i  (resolution_i),
    .busy          (busy),
    .valid_o       (valid_o),
    .sign_o        (sign_o),
    .int_bcd_o     (int_bcd_o),
    .frac_bcd_o    (frac_bcd_o),
    .overrun_o     (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value = word/128 degC, digits by integer arithmetic.
  // Returns {sign, int_bcd[11:0], frac_bcd[15:0]}.
  function automatic logic [28:0] model(input logic [15:0] w, input logic res);
    logic [15:0] wm;
    int v, m, ip, fp;
    logic [11:0] ib;
    logic [15:0] fb;
    wm = res ? w : (w & 16'hFFF8);
    v  = int'($signed(wm));
    m  = (v < 0) ? -v : v;
    ip = m / 128;
    fp = ((m % 128) * 10000) / 128;
    ib = {4'(ip / 100), 4'((ip / 10) % 10), 4'(ip % 10)};
    fb = {4'(fp / 1000), 4'((fp / 100) % 10), 4'((fp / 10) % 10), 4'(fp % 10)};
    return {(v < 0), ib, fb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word for one cycle; returns in cycle 1 of the conversion.
  // The inputs are then scrambled to show they are not re-sampled.
  task automatic start(input logic [15:0] w, input logic res);
    valid_i       = 1'b1;
    temperature_i = w;
    resolution_i  = res;
    tick();
    valid_i       = 1'b0;
    temperature_i = 16'($urandom);
    resolution_i  = 1'($urandom);
  endtask

  // Wait (bounded) for valid_o starting from cycle 'c0', then check
  // latency and the result; ends in the DONE cycle.
  task automatic finish_check(input string tag, input logic [15:0] w,
                              input logic res, input int c0);
    logic [28:0] e;
    int c;
    e = model(w, res);
    c = c0;
    while (!valid_o && c < 40) begin
      tick();
      c++;
    end
    chk({tag, "_latency"}, c, 14);
    chk({tag, "_busy_done"}, busy, 1'b1);
    chk({tag, "_result"}, {sign_o, int_bcd_o, frac_bcd_o}, e);
    $display("conv %s word=0x%04h res=%0d -> sign=%0d int=%03h frac=%04h",
             tag, w, res, sign_o, int_bcd_o, frac_bcd_o);
  endtask

  task automatic run(input string tag, input logic [15:0] w, input logic res);
    start(w, res);
    chk({tag, "_busy_c1"}, busy, 1'b1);
    finish_check(tag, w, res, 1);
    tick();
    chk({tag, "_idle_after"}, {busy, valid_o}, 2'b00);
  endtask

  initial begin
    logic [15:0] w;
    logic        r;
    int          seen;

    rst           = 1'b1;
    valid_i       = 1'b0;
    temperature_i = 16'h0;
    resolution_i  = 1'b0;
    tick();
    tick();
    chk("reset_outputs", {busy, valid_o, sign_o, int_bcd_o, frac_bcd_o, overrun_o}, 33'h0);
    rst = 1'b0;
    tick();

    // Directed vectors
    run("p25",     16'h0C80, 1'b1);
    run("p25_75",  16'h0CE0, 1'b1);
    run("lsb",     16'h0001, 1'b1);
    run("n25",     16'hF380, 1'b1);
    run("n1",      16'hFF80, 1'b1);
    run("n256",    16'h8000, 1'b1);
    run("m13",     16'h0C87, 1'b0);
    run("m16",     16'h0C87, 1'b1);
    run("zero",    16'h0000, 1'b1);
    run("maxpos",  16'h7FFF, 1'b1);
    run("n_lsb",   16'hFFFF, 1'b1);

    // Overrun: second strobe 5 cycles after the first is dropped.
    start(16'h0CE0, 1'b1);
    tick(); tick(); tick(); tick();            // cycle 5
    valid_i       = 1'b1;
    temperature_i = 16'h8000;
    resolution_i  = 1'b1;
    tick();                                    // cycle 6
    valid_i = 1'b0;
    chk("ovr_flag", overrun_o, 1'b1);
    chk("ovr_busy", busy, 1'b1);
    finish_check("ovr", 16'h0CE0, 1'b1, 6);
    tick();
    chk("ovr_sticky", {busy, overrun_o}, 2'b01);
    start(16'hFF80, 1'b1);
    chk("ovr_clear", overrun_o, 1'b0);
    finish_check("after_ovr", 16'hFF80, 1'b1, 1);

    // Strobe during DONE is ignored and flagged; strobe right after is taken.
    valid_i       = 1'b1;
    temperature_i = 16'h0C80;
    resolution_i  = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("done_strobe", {busy, overrun_o}, 2'b01);
    start(16'hF380, 1'b1);
    chk("post_done_accept", {busy, overrun_o}, 2'b10);
    finish_check("post_done", 16'hF380, 1'b1, 1);
    tick();

    // Reset mid-conversion at cycle 7.
    start(16'h0C87, 1'b1);
    tick(); tick(); tick(); tick(); tick(); tick();   // cycle 7
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {busy, valid_o, sign_o, int_bcd_o, frac_bcd_o, overrun_o}, 33'h0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid_o || busy) seen++;
      tick();
    end
    chk("rst_no_valid", seen, 0);
    run("after_rst", 16'hFE70, 1'b1);

    // Random words in both modes
    for (int i = 0; i < 24; i++) begin
      w = 16'($urandom);
      r = 1'($urandom_range(0, 1));
      run($sformatf("rand%0d", i), w, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tmp2_bcd.md
# tmp2_bcd

Downstream formatter for the Pmod TMP2 interface. It captures each raw 16-bit ADT7420 temperature word together with its resolution setting and converts it to sign-magnitude decimal: 3 BCD integer digits and 4 truncated BCD fraction digits. Its outputs drive seven-segment and UART display blocks. Conversion is sequential: a 9-step double-dabble for the integer part, then 4 multiply-by-10 steps for the fraction.

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock, same domain as the interface's valid strobe
- rst  input  1  reset, asynchronous, active-high
- valid_i  input  1  one-cycle strobe; new raw word on temperature_i
- temperature_i  input  16  raw two's-complement temperature register value
- resolution_i  input  1  1 = 16-bit mode (LSB 1/128 °C); 0 = 13-bit mode (bits [2:0] are flags)
- busy  output  1  conversion in progress
- valid_o  output  1  one-cycle pulse; result outputs updated
- sign_o  output  1  1 = negative temperature
- int_bcd_o  output  12  integer magnitude, 3 BCD digits, hundreds in [11:8]
- frac_bcd_o  output  16  fraction, 4 BCD digits (tenths in [15:12] … ten-thousandths in [3:0]), truncated
- overrun_o  output  1  sticky; a valid_i arrived while busy

## Operation
- FSM states: IDLE, INT, FRAC, DONE.
- IDLE: on valid_i, latch the word.
  - If resolution_i = 0, force bits [2:0] to 0.
  - sign = word[15]; mag = sign ? -word : word, as a 16-bit unsigned value (0x8000 gives magnitude 0x8000).
  - Load the integer shift source with mag[15:7] (9 bits, 0..256) and frac with mag[6:0].
  - Clear the BCD accumulators and the step counter.
  - Go to INT.
- INT: 9 cycles of double dabble. Each cycle, add 3 to every BCD nibble ≥ 5, then shift left one bit, MSB of the source first. After the 9th step, go to FRAC.
- FRAC: 4 cycles. Each cycle, p = frac × 10 (11 bits); digit = p[10:7], shifted into the fraction accumulator from the right; frac = p[6:0]. After the 4th step, go to DONE.
- DONE: one cycle.
  - Copy sign, the integer accumulator and the fraction accumulator to the outputs.
  - Assert valid_o for this cycle.
  - Return to IDLE.
- Resolution in both modes reduces to value/128; 13-bit data is handled exactly because its low 3 bits are zero.
- Negative zero cannot occur: a word of 0 gives sign_o = 0.
- busy = (state != IDLE).
- Result outputs hold their last values between conversions.

## Timing
- valid_i sampled in IDLE at cycle 0.
  - INT occupies cycles 1–9.
  - FRAC occupies cycles 10–13.
  - DONE, with valid_o high, is cycle 14.
  - Latency is 14 cycles. Accepted throughput is one word per 15 cycles.
- busy is high from cycle 1 through cycle 14 inclusive and low in IDLE.
- valid_i while busy (including in DONE):
  - The word is ignored and overrun_o is set to 1.
  - overrun_o clears on the next accepted valid_i.
- valid_i in the cycle after DONE (back in IDLE) is accepted normally.
- temperature_i and resolution_i are sampled only in the accepting cycle; later changes have no effect on the conversion in progress.
- Reset at any time, including mid-conversion:
  - Immediately returns the FSM to IDLE.
  - All outputs go to 0: busy, valid_o, sign_o, int_bcd_o, frac_bcd_o, overrun_o.
  - The partial result is discarded and no valid_o is produced.

## Test plan
- 16-bit mode, 0x0C80 → after 14 cycles valid_o pulses; sign_o = 0, int_bcd_o = 0x025, frac_bcd_o = 0x0000.
- 16-bit mode, 0x0CE0 → 25.7500 (int 0x025, frac 0x7500). Also 0x0001 → 0.0078 (int 0x000, frac 0x0078).
- Negative values:
  - 0xF380 → sign 1, int 0x025, frac 0x0000.
  - 0xFF80 → sign 1, int 0x001.
  - 0x8000 → sign 1, int 0x256, frac 0x0000.
- 13-bit mode, 0x0C87 → flag bits masked; 25.0000. The same word in 16-bit mode → 25.0546 (frac 0x0546).
- Overrun: two valid_i strobes 5 cycles apart → only the first is converted, overrun_o = 1, busy unchanged. The next valid_i after busy falls → accepted and overrun_o = 0.
- Reset mid-conversion: rst asserted at cycle 7 → all outputs 0 and no valid_o. A fresh valid_i after rst is released converts correctly with 14-cycle latency.
